// File: rtl/victim_cache_pkg.sv
// Shared types and defaults for the victim-cache tag store.
package victim_cache_pkg;

    localparam int DEF_TAG_WIDTH = 26;
    localparam int DEF_NUM_WAYS  = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WB,
        DONE
    } flush_state_t;

endpackage

// File: rtl/lru_age_tracker.sv
// True-LRU age registers: age 0 is MRU, age NUM_WAYS-1 is the victim.
module lru_age_tracker #(
    parameter int  NUM_WAYS = 8,
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           touch_en,
    input  logic [WAY_W-1:0]               touch_way,
    output logic [WAY_W-1:0]               lru_way,
    output logic [NUM_WAYS-1:0][WAY_W-1:0] ages
);

    logic [NUM_WAYS-1:0][WAY_W-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        if (touch_en) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (i == int'(touch_way)) begin
                    age_d[i] = '0;
                end else if (age_q[i] < age_q[touch_way]) begin
                    age_d[i] = age_q[i] + WAY_W'(1);
                end
            end
        end
    end

    always_comb begin
        lru_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (age_q[i] == WAY_W'(NUM_WAYS - 1)) begin
                lru_way = WAY_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                age_q[i] <= WAY_W'(i);
            end
        end else begin
            age_q <= age_d;
        end
    end

    assign ages = age_q;

endmodule

// File: rtl/victim_tag_array.sv
// Fully associative victim-cache tag store with LRU victim choice
// and a write-back flush engine; holds tags and state bits only.
module victim_tag_array
    import victim_cache_pkg::*;
#(
    parameter int  TAG_WIDTH = DEF_TAG_WIDTH,
    parameter int  NUM_WAYS  = DEF_NUM_WAYS,
    localparam int WAY_W     = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lookup_en,
    input  logic [TAG_WIDTH-1:0] lookup_tag,
    input  logic                 lookup_inval,
    output logic                 hit,
    output logic [WAY_W-1:0]     hit_way,
    output logic                 hit_dirty,
    input  logic                 alloc_en,
    input  logic [TAG_WIDTH-1:0] alloc_tag,
    input  logic                 alloc_dirty,
    output logic [WAY_W-1:0]     alloc_way,
    output logic                 evict_valid,
    output logic [TAG_WIDTH-1:0] evict_tag,
    output logic                 evict_dirty,
    input  logic                 dirty_set_en,
    input  logic [WAY_W-1:0]     dirty_way,
    input  logic                 flush_req,
    output logic                 flush_busy,
    output logic                 wb_valid,
    output logic [TAG_WIDTH-1:0] wb_tag,
    output logic [WAY_W-1:0]     wb_way,
    input  logic                 wb_ready,
    output logic                 flush_done
);

    localparam logic [WAY_W-1:0] LAST = WAY_W'(NUM_WAYS - 1);

    logic [NUM_WAYS-1:0]                valid_q, valid_d;
    logic [NUM_WAYS-1:0]                dirty_q, dirty_d;
    logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] tag_q, tag_d;
    flush_state_t                       state_q;
    logic [WAY_W-1:0]                   idx_q;

    logic                 hit_q, hit_dirty_q, evict_valid_q, evict_dirty_q;
    logic [WAY_W-1:0]     hit_way_q, alloc_way_q;
    logic [TAG_WIDTH-1:0] evict_tag_q;

    logic                           busy, lk_en, al_en, ds_en;
    logic                           lk_hit, al_hit, any_free, evict;
    logic [WAY_W-1:0]               lk_way, al_mway, free_way, al_way;
    logic [WAY_W-1:0]               lru_way;
    logic [NUM_WAYS-1:0][WAY_W-1:0] ages;
    logic                           touch_en;
    logic [WAY_W-1:0]               touch_way;

    assign busy  = (state_q != IDLE);
    assign lk_en = lookup_en & ~busy;
    assign al_en = alloc_en & ~busy;
    assign ds_en = dirty_set_en & ~busy;

    // Descending scans so the lowest matching index wins.
    always_comb begin
        lk_hit   = 1'b0;
        lk_way   = '0;
        al_hit   = 1'b0;
        al_mway  = '0;
        any_free = 1'b0;
        free_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == lookup_tag) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(i);
            end
            if (valid_q[i] && tag_q[i] == alloc_tag) begin
                al_hit  = 1'b1;
                al_mway = WAY_W'(i);
            end
            if (!valid_q[i]) begin
                any_free = 1'b1;
                free_way = WAY_W'(i);
            end
        end
    end

    assign al_way = al_hit ? al_mway : (any_free ? free_way : lru_way);
    assign evict  = al_en & ~al_hit & ~any_free;

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        if (ds_en && valid_q[dirty_way]) begin
            dirty_d[dirty_way] = 1'b1;
        end
        if (lk_en && lookup_inval && lk_hit) begin
            valid_d[lk_way] = 1'b0;
            dirty_d[lk_way] = 1'b0;
        end
        if (al_en) begin
            valid_d[al_way] = 1'b1;
            tag_d[al_way]   = alloc_tag;
            dirty_d[al_way] = (al_hit & dirty_q[al_way]) | alloc_dirty
                            | (ds_en & (dirty_way == al_way));
        end
        if (state_q == WB && wb_ready) begin
            dirty_d[idx_q] = 1'b0;
        end
    end

    // Touching the current MRU way leaves every age unchanged, so skip it.
    assign touch_way = al_en ? al_way : lk_way;
    assign touch_en  = (al_en | (lk_en & lk_hit & ~lookup_inval))
                     & (ages[touch_way] != '0);

    lru_age_tracker #(
        .NUM_WAYS(NUM_WAYS)
    ) u_lru (
        .clk      (clk),
        .rst_n    (rst_n),
        .touch_en (touch_en),
        .touch_way(touch_way),
        .lru_way  (lru_way),
        .ages     (ages)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            dirty_q       <= '0;
            tag_q         <= '0;
            hit_q         <= 1'b0;
            hit_way_q     <= '0;
            hit_dirty_q   <= 1'b0;
            alloc_way_q   <= '0;
            evict_valid_q <= 1'b0;
            evict_tag_q   <= '0;
            evict_dirty_q <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            dirty_q       <= dirty_d;
            tag_q         <= tag_d;
            hit_q         <= lk_en & lk_hit;
            hit_way_q     <= (lk_en & lk_hit) ? lk_way : '0;
            hit_dirty_q   <= lk_en & lk_hit & dirty_q[lk_way];
            evict_valid_q <= evict;
            evict_tag_q   <= evict ? tag_q[al_way] : '0;
            evict_dirty_q <= evict & dirty_q[al_way];
            if (al_en) begin
                alloc_way_q <= al_way;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (flush_req) begin
                        state_q <= SCAN;
                        idx_q   <= '0;
                    end
                end
                SCAN: begin
                    if (valid_q[idx_q] && dirty_q[idx_q]) begin
                        state_q <= WB;
                    end else if (idx_q == LAST) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + WAY_W'(1);
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        if (idx_q == LAST) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= SCAN;
                            idx_q   <= idx_q + WAY_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign hit         = hit_q;
    assign hit_way     = hit_way_q;
    assign hit_dirty   = hit_dirty_q;
    assign alloc_way   = alloc_way_q;
    assign evict_valid = evict_valid_q;
    assign evict_tag   = evict_tag_q;
    assign evict_dirty = evict_dirty_q;
    assign flush_busy  = busy;
    assign wb_valid    = (state_q == WB);
    assign wb_way      = wb_valid ? idx_q : '0;
    assign wb_tag      = wb_valid ? tag_q[idx_q] : '0;
    assign flush_done  = (state_q == DONE);

endmodule

// File: tb/tb_victim_tag_array.sv
// Bench for victim_tag_array: directed scenarios plus random traffic
// against a recency-list / event-script reference model.
module tb_victim_tag_array;

    localparam int TW = 4;
    localparam int NW = 4;
    localparam int WW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lookup_en = 1'b0, lookup_inval = 1'b0;
    logic [TW-1:0] lookup_tag = '0;
    logic          hit, hit_dirty;
    logic [WW-1:0] hit_way;
    logic          alloc_en = 1'b0, alloc_dirty = 1'b0;
    logic [TW-1:0] alloc_tag = '0;
    logic [WW-1:0] alloc_way;
    logic          evict_valid, evict_dirty;
    logic [TW-1:0] evict_tag;
    logic          dirty_set_en = 1'b0;
    logic [WW-1:0] dirty_way = '0;
    logic          flush_req = 1'b0, flush_busy, wb_valid, wb_ready = 1'b0;
    logic [TW-1:0] wb_tag;
    logic [WW-1:0] wb_way;
    logic          flush_done;

    victim_tag_array #(.TAG_WIDTH(TW), .NUM_WAYS(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_en(lookup_en), .lookup_tag(lookup_tag),
        .lookup_inval(lookup_inval),
        .hit(hit), .hit_way(hit_way), .hit_dirty(hit_dirty),
        .alloc_en(alloc_en), .alloc_tag(alloc_tag),
        .alloc_dirty(alloc_dirty), .alloc_way(alloc_way),
        .evict_valid(evict_valid), .evict_tag(evict_tag),
        .evict_dirty(evict_dirty),
        .dirty_set_en(dirty_set_en), .dirty_way(dirty_way),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_way(wb_way),
        .wb_ready(wb_ready), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    // Reference model: contents, recency list (MRU first), flush script.
    bit          mv[NW];
    bit          md[NW];
    logic [TW-1:0] mt[NW];
    int          rec[$];
    int          fq[$];
    bit          e_hit, e_hd, e_ev, e_evd;
    int          e_hway, e_aw;
    logic [TW-1:0] e_evt;

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            mv[i] = 0; md[i] = 0; mt[i] = '0;
        end
        rec.delete();
        for (int i = 0; i < NW; i++) rec.push_back(i);
        fq.delete();
        e_hit = 0; e_hd = 0; e_ev = 0; e_evd = 0;
        e_hway = 0; e_aw = 0; e_evt = '0;
    endtask

    task automatic touch(input int w);
        for (int i = 0; i < rec.size(); i++) begin
            if (rec[i] == w) begin
                rec.delete(i);
                break;
            end
        end
        rec.push_front(w);
    endtask

    task automatic model_step();
        bit pv[NW];
        bit pd[NW];
        logic [TW-1:0] pt[NW];
        int h, m, tgt;
        bit full;
        e_hit = 0; e_hway = 0; e_hd = 0;
        e_ev = 0; e_evt = '0; e_evd = 0;
        if (fq.size() > 0) begin
            if (fq[0] / 16 == 2) begin
                if (wb_ready) begin
                    md[fq[0] % 16] = 0;
                    void'(fq.pop_front());
                end
            end else begin
                void'(fq.pop_front());
            end
            return;
        end
        for (int i = 0; i < NW; i++) begin
            pv[i] = mv[i]; pd[i] = md[i]; pt[i] = mt[i];
        end
        h = -1; m = -1; tgt = -1; full = 1;
        for (int i = NW - 1; i >= 0; i--) begin
            if (pv[i] && pt[i] == lookup_tag) h = i;
            if (pv[i] && pt[i] == alloc_tag) m = i;
            if (!pv[i]) begin
                full = 0;
                tgt = i;
            end
        end
        if (lookup_en && h >= 0) begin
            e_hit = 1; e_hway = h; e_hd = pd[h];
        end
        if (dirty_set_en && pv[dirty_way]) md[dirty_way] = 1;
        if (lookup_en && lookup_inval && h >= 0) begin
            mv[h] = 0; md[h] = 0;
        end
        if (alloc_en) begin
            if (m >= 0) tgt = m;
            else if (full) tgt = rec[$];
            e_ev = (m < 0) && full;
            if (e_ev) begin
                e_evt = pt[tgt]; e_evd = pd[tgt];
            end
            mv[tgt] = 1;
            mt[tgt] = alloc_tag;
            md[tgt] = ((m >= 0) && pd[tgt]) || alloc_dirty ||
                      (dirty_set_en && dirty_way == tgt);
            e_aw = tgt;
            touch(tgt);
        end else if (lookup_en && h >= 0 && !lookup_inval) begin
            touch(h);
        end
        if (flush_req) begin
            for (int w = 0; w < NW; w++) begin
                fq.push_back(16 + w);
                if (mv[w] && md[w]) fq.push_back(32 + w);
            end
            fq.push_back(48);
        end
    endtask

    task automatic compare();
        int  k, w;
        bit  wbv;
        k = 0; w = 0;
        if (fq.size() > 0) begin
            k = fq[0] / 16;
            w = fq[0] % 16;
        end
        wbv = (k == 2);
        chk("hit", hit, e_hit);
        chk("hit_way", hit_way, e_hway);
        chk("hit_dirty", hit_dirty, e_hd);
        chk("alloc_way", alloc_way, e_aw);
        chk("evict_valid", evict_valid, e_ev);
        chk("evict_tag", evict_tag, e_evt);
        chk("evict_dirty", evict_dirty, e_evd);
        chk("flush_busy", flush_busy, fq.size() != 0);
        chk("wb_valid", wb_valid, wbv);
        chk("wb_way", wb_way, wbv ? w : 0);
        chk("wb_tag", wb_tag, wbv ? mt[w] : '0);
        chk("flush_done", flush_done, k == 3);
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare();
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        lookup_en = 0; lookup_inval = 0; alloc_en = 0; alloc_dirty = 0;
        dirty_set_en = 0; flush_req = 0;
    endtask

    task automatic do_alloc(input logic [TW-1:0] t, input logic d);
        clr(); alloc_en = 1; alloc_tag = t; alloc_dirty = d;
        tick(); clr();
    endtask

    task automatic do_lookup(input logic [TW-1:0] t, input logic inv);
        clr(); lookup_en = 1; lookup_tag = t; lookup_inval = inv;
        tick(); clr();
    endtask

    localparam logic [TW-1:0] A = 4'd1, B = 4'd2, C = 4'd3;
    localparam logic [TW-1:0] D = 4'd4, E = 4'd5, F = 4'd6;

    initial begin
        int busy_n, obs0, c;
        bit done;
        int seq[$];
        logic [TW-1:0] tags[4];
        tags[0] = A; tags[1] = B; tags[2] = C; tags[3] = D;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst hit", hit, 0);
        chk("rst busy", flush_busy, 0);
        chk("rst evict_tag", evict_tag, 0);
        rst_n = 1;
        tick();

        // 1: fill, then lookup C
        for (int i = 0; i < 4; i++) begin
            do_alloc(tags[i], 0);
            chk("s1 alloc_way", alloc_way, i);
            chk("s1 no evict", evict_valid, 0);
        end
        do_lookup(C, 0);
        chk("s1 hit", hit, 1);
        chk("s1 hit_way", hit_way, 2);

        // 2: touch A, allocate E -> B evicted from way 1
        do_lookup(A, 0);
        do_alloc(E, 1);
        chk("s2 evict_valid", evict_valid, 1);
        chk("s2 evict_tag", evict_tag, B);
        chk("s2 evict_dirty", evict_dirty, 0);
        chk("s2 alloc_way", alloc_way, 1);

        // 3: dirty way 2, invalidating lookup, refill hole
        clr(); dirty_set_en = 1; dirty_way = 2; tick(); clr();
        do_lookup(C, 1);
        chk("s3 hit", hit, 1);
        chk("s3 hit_dirty", hit_dirty, 1);
        do_lookup(C, 0);
        chk("s3 miss", hit, 0);
        do_alloc(F, 0);
        chk("s3 alloc_way", alloc_way, 2);
        chk("s3 no evict", evict_valid, 0);

        // 4: in-place dirty alloc
        do_alloc(A, 1);
        chk("s4 alloc_way", alloc_way, 0);
        chk("s4 no evict", evict_valid, 0);
        do_lookup(A, 0);
        chk("s4 hit_dirty", hit_dirty, 1);

        // 5: ways 0 and 3 dirty, stalled flush
        do_lookup(E, 1);
        clr(); dirty_set_en = 1; dirty_way = 3; tick(); clr();
        flush_req = 1; wb_ready = 0; tick(); flush_req = 0;
        busy_n = 0; obs0 = 0; done = 0;
        for (c = 0; c < 40 && !done; c++) begin
            if (flush_busy) busy_n++;
            if (wb_valid) begin
                if (seq.size() == 0 || seq[$] != int'(wb_way))
                    seq.push_back(int'(wb_way));
                if (wb_way == 0) obs0++;
            end
            if (flush_done) done = 1;
            wb_ready = wb_valid && (wb_way != 0 || obs0 >= 3);
            if (!done) tick();
        end
        chk("s5 done seen", done, 1);
        chk("s5 busy cycles", busy_n, 9);
        chk("s5 wb count", seq.size(), 2);
        if (seq.size() == 2) begin
            chk("s5 wb first", seq[0], 0);
            chk("s5 wb second", seq[1], 3);
        end
        wb_ready = 0;
        tick();
        do_lookup(A, 0);
        chk("s5 A hit", hit, 1);
        chk("s5 A clean", hit_dirty, 0);
        do_lookup(D, 0);
        chk("s5 D hit", hit, 1);
        chk("s5 D clean", hit_dirty, 0);

        // 6: reset while a write-back is pending
        do_alloc(D, 1);
        flush_req = 1; tick(); flush_req = 0;
        for (c = 0; c < 20 && !wb_valid; c++) tick();
        chk("s6 wb reached", wb_valid, 1);
        #1 rst_n = 0;
        #1;
        chk("s6 wb_valid drop", wb_valid, 0);
        chk("s6 busy drop", flush_busy, 0);
        chk("s6 hit drop", hit, 0);
        clr();
        tick(); tick();
        rst_n = 1;
        for (int i = 0; i < NW; i++)
            chk("s6 age", dut.u_lru.ages[i], i);
        for (int t = 1; t <= 6; t++) begin
            do_lookup(4'(t), 0);
            chk("s6 miss", hit, 0);
        end

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            lookup_en    = 1'($urandom_range(0, 1));
            lookup_tag   = 4'($urandom_range(0, 6));
            lookup_inval = ($urandom_range(0, 3) == 0);
            alloc_en     = ($urandom_range(0, 4) < 2);
            alloc_tag    = 4'($urandom_range(0, 6));
            alloc_dirty  = 1'($urandom_range(0, 1));
            dirty_set_en = ($urandom_range(0, 4) == 0);
            dirty_way    = 2'($urandom_range(0, 3));
            flush_req    = ($urandom_range(0, 39) == 0);
            wb_ready     = ($urandom_range(0, 9) < 6);
            tick();
        end
        clr();
        wb_ready = 1;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/victim_tag_array.md
# victim_tag_array

Parametrised, fully associative tag array for the victim cache. It succeeds the fixed 4-way tag store and adds:

- true-LRU replacement with automatic victim selection;
- registered lookup with optional invalidate-on-hit (swap-back to L1);
- eviction reporting for write-back;
- a flush engine that streams every dirty entry out over a valid/ready handshake.

It sits between the victim-cache controller and the data array: it supplies way indices and write-back tags only and holds no data.

## Interface

Parameters:

- TAG_WIDTH, default 26: tag bits stored per way.
- NUM_WAYS, default 8: number of ways; a power of two, 2 or more. WAY_W = $clog2(NUM_WAYS) is derived.

Ports:

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lookup_en  in  1  lookup strobe.
- lookup_tag  in  TAG_WIDTH  tag searched.
- lookup_inval  in  1  with lookup_en: clear valid and dirty of the hit way.
- hit  out  1  registered lookup result.
- hit_way  out  WAY_W  way that matched; 0 on a miss.
- hit_dirty  out  1  dirty bit of the matched way before any invalidation.
- alloc_en  in  1  allocate strobe.
- alloc_tag  in  TAG_WIDTH  tag to insert.
- alloc_dirty  in  1  initial dirty bit.
- alloc_way  out  WAY_W  way written; registered.
- evict_valid  out  1  one-cycle pulse: a valid entry was displaced.
- evict_tag  out  TAG_WIDTH  displaced tag.
- evict_dirty  out  1  displaced entry needs write-back.
- dirty_set_en  in  1  set the dirty bit of dirty_way.
- dirty_way  in  WAY_W  target way for dirty_set_en.
- flush_req  in  1  start a flush; sampled only in IDLE.
- flush_busy  out  1  high from the cycle after flush_req until flush_done.
- wb_valid  out  1  write-back entry presented.
- wb_tag  out  TAG_WIDTH  tag of the entry being written back.
- wb_way  out  WAY_W  way of the entry being written back.
- wb_ready  in  1  consumer accepts the write-back.
- flush_done  out  1  one-cycle pulse at the end of a flush.

## Operation

Reset state:

- All valid and dirty bits 0.
- Per-way LRU ages set to age[i] = i, so way NUM_WAYS-1 is the oldest.
- FSM in IDLE.
- Every output is 0.

Lookup:

- Compare lookup_tag against all valid ways.
- On a hit without inval: the hit way becomes MRU.
- On a hit with lookup_inval: clear valid and dirty of the hit way; LRU is unchanged.
- A miss changes no state.

Allocate:

- If alloc_tag already matches a valid way, update that way in place: dirty |= alloc_dirty, the way becomes MRU, and there is no eviction.
- Otherwise the target is the lowest-index invalid way. If every way is valid, the target is the way with age NUM_WAYS-1; its old tag and dirty bit appear on evict_* with evict_valid=1.
- The target is written valid with alloc_tag and alloc_dirty, and becomes MRU.

LRU update on a touch of way w with old age a:

- age[w] ← 0.
- Every way with age < a increments.
- Ages remain a permutation of 0..NUM_WAYS-1 at all times.

Simultaneous events within one cycle:

- The lookup sees pre-cycle state.
- If alloc_en and lookup_en are both high, only the alloc touches LRU.
- If the lookup invalidates the way that the alloc selects, the alloc still writes it.
- If dirty_set_en targets the alloc target, the written dirty bit is alloc_dirty | 1.
- dirty_set_en on an invalid way is ignored.

Flush FSM states: IDLE → SCAN → WB → SCAN … → DONE → IDLE.

- SCAN examines way idx, starting at 0.
  - If the way is valid and dirty, go to WB.
  - Otherwise increment idx.
  - After idx = NUM_WAYS-1 is resolved, go to DONE.
- WB drives wb_valid=1 with wb_tag and wb_way, held stable until wb_ready. On the handshake the dirty bit is cleared, idx increments, and the FSM returns to SCAN, or goes to DONE if this was the last way.
- DONE pulses flush_done for one cycle.
- Entries remain valid (clean) after a flush.
- While flush_busy is high, lookup_en, alloc_en and dirty_set_en are ignored and hit/evict_valid stay 0.
- flush_req while busy is ignored.

## Timing

- hit, hit_way, hit_dirty, alloc_way and evict_* are valid exactly 1 cycle after the strobe. hit and evict_valid are one-cycle pulses.
- Back-to-back strobes every cycle are supported. Each result reflects state including all updates from earlier cycles.
- Flush duration:
  - one SCAN cycle per way;
  - plus one WB cycle per dirty way, plus wb_ready stall cycles;
  - plus one DONE cycle.
  - A flush with no dirty entries takes NUM_WAYS+1 cycles of flush_busy.
- wb_valid must not drop before wb_ready is seen.
- If rst_n is asserted mid-flush, all state returns to the reset values immediately and no flush_done is produced.

## Structure

- victim_cache_pkg holds:
  - the flush_state_t enum (IDLE, SCAN, WB, DONE);
  - the shared parameters for TAG_WIDTH and NUM_WAYS defaults.
- Sub-module lru_age_tracker, parametrised by NUM_WAYS:
  - inputs: touch_en, touch_way;
  - outputs: lru_way, ages;
  - holds the age registers and the update rule.
- Tag/valid/dirty arrays, match logic and the flush FSM live in victim_tag_array.

## Test plan

All scenarios run with TAG_WIDTH=4, NUM_WAYS=4.

1. Alloc A, B, C, D clean → alloc_way 0,1,2,3, evict_valid never asserted. Lookup C → hit=1, hit_way=2.
2. After scenario 1, lookup A, then alloc E dirty → the victim is way 1 (B). evict_valid=1, evict_tag=B, evict_dirty=0, alloc_way=1.
3. dirty_set way 2, then lookup C with lookup_inval → hit=1, hit_dirty=1. A repeated lookup of C → hit=0. The next alloc of F → alloc_way=2, no eviction.
4. Alloc A with alloc_dirty=1 while A is already resident in way 0 → alloc_way=0, no evict_valid. A later lookup of A → hit_dirty=1.
5. With ways 0 and 3 dirty, flush_req while wb_ready is held low for 3 cycles → wb_valid is held with wb_way=0 until ready, then wb_way=3. flush_done occurs after 9 busy cycles. All dirty bits are 0 afterwards and lookups still hit.
6. rst_n asserted during WB → wb_valid, flush_busy and hit drop to 0 asynchronously. After release, every lookup misses and ages are 0..3.
